// File: rtl/axi_dbg_pkg.sv
// Shared types and constants for the debug-port AXI4 slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Largest beat size the 32-bit device port can carry (4 bytes).
    localparam logic [2:0] SIZE_MAX = 3'd2;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address and unsupported-transaction flag from (addr, size, burst).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when to register the result.
module axi_burst_addr_gen
    import axi_dbg_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              err
);

    // FIXED holds, INCR steps by the beat size (wrapping silently), WRAP/reserved are rejected.
    always_comb begin
        next_addr = addr;
        err       = (size > SIZE_MAX) || (burst == BURST_WRAP) || (burst == 2'b11);
        if (burst == BURST_INCR) begin
            next_addr = addr + (ADDR_W'(1) << size);
        end
    end

endmodule

// File: rtl/axi_dbg_mem_slave.sv
// AXI4 slave bridging the debug crossbar port onto a single-port device memory bus.
// Latency: AR handshake -> rvalid 3 cycles, 3 cycles per further read beat; write beats go out the cycle they are accepted.
// Backpressure: one transaction at a time; R/B held until rready/bready, device side is never stalled.
module axi_dbg_mem_slave
    import axi_dbg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    // write address
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    // write data
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    // write response
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    // read address
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    // read data
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    // device port
    output logic              dev_req,
    output logic              dev_we,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [3:0]        dev_be,
    output logic [DATA_W-1:0] dev_wdata,
    input  logic [DATA_W-1:0] dev_rdata
);

    state_t              state, state_nxt;
    logic                last_rd;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          beat_cnt;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                wlast_err_q;

    logic [ADDR_W-1:0]   next_addr;
    logic                txn_err;
    logic                rd_grant;
    logic                wr_grant;
    logic                last_beat;
    logic [ADDR_W-1:0]   word_addr;

    // Only one transaction is in flight, so a single generator serves both paths.
    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .err       (txn_err)
    );

    // On a tie the pointer picks the side that did not win the previous tie; lone requests win outright.
    assign rd_grant  = s_axi_arvalid && (!s_axi_awvalid || !last_rd);
    assign wr_grant  = s_axi_awvalid && !rd_grant;
    assign last_beat = (beat_cnt == 8'd0);
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; burst length comes from len, never from wlast.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_grant)      state_nxt = RD_REQ;
                else if (wr_grant) state_nxt = WR_DATA;
            end
            RD_REQ:  state_nxt = RD_CAP;
            RD_CAP:  state_nxt = RD_RESP;
            RD_RESP: begin
                if (s_axi_rready) state_nxt = last_beat ? IDLE : RD_REQ;
            end
            WR_DATA: begin
                if (s_axi_wvalid && last_beat) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi_bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Channel and device outputs; everything idles at zero, and an erroring transaction never touches the device.
    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        s_axi_rid     = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = RESP_OKAY;
        s_axi_bvalid  = 1'b0;
        s_axi_bid     = '0;
        s_axi_bresp   = RESP_OKAY;
        dev_req       = 1'b0;
        dev_we        = 1'b0;
        dev_addr      = '0;
        dev_be        = 4'h0;
        dev_wdata     = '0;
        case (state)
            IDLE: begin
                s_axi_arready = rd_grant && !rst;
                s_axi_awready = wr_grant && !rst;
            end
            RD_REQ: begin
                if (!txn_err) begin
                    dev_req  = 1'b1;
                    dev_addr = word_addr;
                    dev_be   = 4'hF;
                end
            end
            RD_RESP: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = last_beat;
                s_axi_rid    = id_q;
                s_axi_rdata  = rdata_q;
                s_axi_rresp  = txn_err ? RESP_SLVERR : RESP_OKAY;
            end
            WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && !txn_err) begin
                    dev_req   = 1'b1;
                    dev_we    = 1'b1;
                    dev_addr  = word_addr;
                    dev_be    = s_axi_wstrb;
                    dev_wdata = s_axi_wdata;
                end
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = id_q;
                s_axi_bresp  = (txn_err || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    // Transaction context: capture on grant, step address/count per beat, latch read data and wlast violations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd     <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            beat_cnt    <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= BURST_FIXED;
            rdata_q     <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_grant) begin
                        id_q     <= s_axi_arid;
                        addr_q   <= s_axi_araddr;
                        beat_cnt <= s_axi_arlen;
                        size_q   <= s_axi_arsize;
                        burst_q  <= s_axi_arburst;
                        if (s_axi_awvalid) last_rd <= !last_rd;
                    end else if (wr_grant) begin
                        id_q        <= s_axi_awid;
                        addr_q      <= s_axi_awaddr;
                        beat_cnt    <= s_axi_awlen;
                        size_q      <= s_axi_awsize;
                        burst_q     <= s_axi_awburst;
                        wlast_err_q <= 1'b0;
                        if (s_axi_arvalid) last_rd <= !last_rd;
                    end
                end
                RD_CAP: begin
                    rdata_q <= txn_err ? '0 : dev_rdata;
                end
                RD_RESP: begin
                    if (s_axi_rready && !last_beat) begin
                        addr_q   <= next_addr;
                        beat_cnt <= beat_cnt - 8'd1;
                    end
                end
                WR_DATA: begin
                    if (s_axi_wvalid) begin
                        if (s_axi_wlast != last_beat) wlast_err_q <= 1'b1;
                        if (!last_beat) begin
                            addr_q   <= next_addr;
                            beat_cnt <= beat_cnt - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dbg_mem_slave.sv
module tb_axi_dbg_mem_slave;
    import axi_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_mem = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        rready = 1'b1, bready = 1'b1;
    logic        awready, arready, wready, bvalid, rvalid, rlast;
    logic        dev_req, dev_we;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    logic [3:0]  dev_be;

    axi_dbg_mem_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_be(dev_be),
        .dev_wdata(dev_wdata), .dev_rdata(dev_rdata)
    );

    // device model: word memory, read data one cycle after the request, junk otherwise
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 + 32'(i);
            mem[10'h040] <= 32'hDEAD_BEEF;
        end else if (dev_req && dev_we) begin
            for (int k = 0; k < 4; k++)
                if (dev_be[k]) mem[dev_addr[11:2]][8*k +: 8] <= dev_wdata[8*k +: 8];
        end
        dev_rdata <= (dev_req && !dev_we) ? mem[dev_addr[11:2]] : 32'hBAD0_BAD0;
    end

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } dev_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
    typedef struct {
        bit wr; logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] sz;
        logic [1:0] bu; logic [3:0] strb; int bad; logic [1:0] resp;
    } vec_t;

    dev_t exp_dev[$];
    r_t   exp_r[$];
    b_t   exp_b[$];

    int tests = 0, fails = 0;
    int cyc = 0;
    int ar_cyc = 0, aw_cyc = 0, req_cyc = 0, rv_cyc = 0;
    bit req_seen = 0, rv_seen = 0;
    int r_hs_cnt = 0, dual_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT activity with no expectation queued", name);
    endtask

    function automatic logic [31:0] next_a(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
        return (bu == BURST_INCR) ? a + (32'd1 << sz) : a;
    endfunction

    // scoreboard monitor, sampled on the falling edge
    initial begin
        dev_t d;
        r_t   r;
        b_t   b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (arready && awready) dual_rdy++;
                if (arvalid && arready) begin ar_cyc = cyc; req_seen = 0; rv_seen = 0; end
                if (awvalid && awready) aw_cyc = cyc;
                if (dev_req) begin
                    if (!req_seen) begin req_cyc = cyc; req_seen = 1; end
                    if (exp_dev.size() == 0) flag_fail("dev_req");
                    else begin
                        d = exp_dev.pop_front();
                        chk("dev_addr", dev_addr, d.addr);
                        chk("dev_we", dev_we, d.we);
                        if (d.we) begin
                            chk("dev_be", dev_be, d.be);
                            chk("dev_wdata", dev_wdata, d.wdata);
                        end
                    end
                end
                if (rvalid) begin
                    if (!rv_seen) begin rv_cyc = cyc; rv_seen = 1; end
                    if (exp_r.size() == 0) flag_fail("rvalid");
                    else begin
                        r = exp_r[0];
                        chk("rid", rid, r.id);
                        chk("rdata", rdata, r.data);
                        chk("rresp", rresp, r.resp);
                        chk("rlast", rlast, r.last);
                        if (rready) begin void'(exp_r.pop_front()); r_hs_cnt++; end
                    end
                end
                if (bvalid) begin
                    if (exp_b.size() == 0) flag_fail("bvalid");
                    else begin
                        b = exp_b[0];
                        chk("bid", bid, b.id);
                        chk("bresp", bresp, b.resp);
                        if (bready) void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_txn(input vec_t v);
        logic [31:0] cur;
        bit err;
        cur = v.addr;
        err = (v.sz > 3'd2) || v.bu[1];
        for (int i = 0; i <= int'(v.len); i++) begin
            if (!err) exp_dev.push_back('{{cur[31:2], 2'b00}, v.wr, v.strb, 32'(i + 1)});
            if (!v.wr) exp_r.push_back('{v.id, err ? 32'h0 : mem[cur[11:2]], v.resp, i == int'(v.len)});
            cur = next_a(cur, v.sz, v.bu);
        end
        if (v.wr) exp_b.push_back('{v.id, v.resp});
    endtask

    task automatic send_ar(input vec_t v);
        int n = 0;
        @(posedge clk); #1;
        arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.sz; arburst = v.bu; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 100) begin @(negedge clk); n++; end
        chk("ar_timeout", n >= 100, 0);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic send_wr(input vec_t v);
        int n = 0;
        @(posedge clk); #1;
        awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.sz; awburst = v.bu; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 100) begin @(negedge clk); n++; end
        chk("aw_timeout", n >= 100, 0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(v.len); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            wdata = 32'(i + 1); wstrb = v.strb;
            wlast = (i == int'(v.len)) ^ (i == v.bad);
            wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!wready && n < 100) begin @(negedge clk); n++; end
            chk("w_timeout", n >= 100, 0);
        end
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_dev.size() + exp_r.size() + exp_b.size()) != 0 && n < 300) begin
            @(negedge clk); n++;
        end
        chk("drain", exp_dev.size() + exp_r.size() + exp_b.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        push_txn(v);
        if (v.wr) send_wr(v);
        else      send_ar(v);
        wait_drain();
    endtask

    vec_t tbl[11];
    vec_t va, vb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = '{0, 4'h3, 32'h0000_0100, 8'd0, 3'd2, BURST_INCR,  4'hF, -1, RESP_OKAY};
        tbl[1]  = '{1, 4'h5, 32'h0000_0200, 8'd3, 3'd2, BURST_INCR,  4'hF, -1, RESP_OKAY};
        tbl[2]  = '{0, 4'h6, 32'h0000_0200, 8'd3, 3'd2, BURST_INCR,  4'hF, -1, RESP_OKAY};
        tbl[3]  = '{0, 4'h1, 32'h0000_0300, 8'd1, 3'd2, BURST_WRAP,  4'hF, -1, RESP_SLVERR};
        tbl[4]  = '{1, 4'h2, 32'h0000_0400, 8'd2, 3'd2, BURST_INCR,  4'hF,  1, RESP_SLVERR};
        tbl[5]  = '{0, 4'h7, 32'h0000_0100, 8'd2, 3'd2, BURST_FIXED, 4'hF, -1, RESP_OKAY};
        tbl[6]  = '{0, 4'h8, 32'h0000_0110, 8'd0, 3'd3, BURST_INCR,  4'hF, -1, RESP_SLVERR};
        tbl[7]  = '{1, 4'h9, 32'h0000_0500, 8'd1, 3'd2, 2'b11,       4'hF, -1, RESP_SLVERR};
        tbl[8]  = '{1, 4'hA, 32'h0000_0402, 8'd1, 3'd1, BURST_INCR,  4'hC, -1, RESP_OKAY};
        tbl[9]  = '{1, 4'hB, 32'h0000_0700, 8'd0, 3'd2, BURST_INCR,  4'h3,  0, RESP_SLVERR};
        tbl[10] = '{0, 4'hC, 32'hFFFF_FFFC, 8'd1, 3'd2, BURST_INCR,  4'hF, -1, RESP_OKAY};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_dev_req", {dev_req, dev_we}, 0);
        chk("rst_dev_bus", {dev_addr, dev_be, dev_wdata}, 0);
        chk("rst_resp", {rdata, rresp, bresp, rid, bid}, 0);
        @(posedge clk); #1;
        init_mem = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // simultaneous AR/AW: read wins first tie, write wins the next
        va = '{0, 4'h9, 32'h0000_0600, 8'd0, 3'd2, BURST_INCR, 4'hF, -1, RESP_OKAY};
        vb = '{1, 4'hA, 32'h0000_0604, 8'd0, 3'd2, BURST_INCR, 4'hF, -1, RESP_OKAY};
        push_txn(va); push_txn(vb);
        fork send_ar(va); send_wr(vb); join
        wait_drain();
        chk("arb1_read_first", ar_cyc < aw_cyc, 1);
        va = '{0, 4'hC, 32'h0000_060C, 8'd0, 3'd2, BURST_INCR, 4'hF, -1, RESP_OKAY};
        vb = '{1, 4'hB, 32'h0000_0608, 8'd0, 3'd2, BURST_INCR, 4'hF, -1, RESP_OKAY};
        push_txn(vb); push_txn(va);
        fork send_ar(va); send_wr(vb); join
        wait_drain();
        chk("arb2_write_first", aw_cyc < ar_cyc, 1);

        // table-driven transactions
        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i]);
            if (i == 0) begin
                chk("lat_dev_req", req_cyc - ar_cyc, 1);
                chk("lat_rvalid", rv_cyc - ar_cyc, 3);
            end
        end
        chk("no_dual_ready", dual_rdy, 0);

        // R backpressure: data held for 4 stalled cycles
        rready = 1'b0;
        va = '{0, 4'h4, 32'h0000_0100, 8'd0, 3'd2, BURST_INCR, 4'hF, -1, RESP_OKAY};
        push_txn(va);
        send_ar(va);
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, 32'hDEAD_BEEF);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        wait_drain();

        // B backpressure on an early-wlast burst
        bready = 1'b0;
        vb = '{1, 4'h6, 32'h0000_0480, 8'd2, 3'd2, BURST_INCR, 4'hF, 1, RESP_SLVERR};
        push_txn(vb);
        send_wr(vb);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bresp", bresp, RESP_SLVERR);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        wait_drain();

        // reset during beat 2 of a 4-beat read
        va = '{0, 4'h6, 32'h0000_0500, 8'd3, 3'd2, BURST_INCR, 4'hF, -1, RESP_OKAY};
        push_txn(va);
        n = r_hs_cnt;
        send_ar(va);
        begin
            int w = 0;
            while (r_hs_cnt == n && w < 50) begin @(negedge clk); w++; end
            chk("midrst_first_beat", r_hs_cnt - n, 1);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        exp_dev.delete(); exp_r.delete(); exp_b.delete();
        #1;
        chk("midrst_valids", {rvalid, bvalid, arready, awready, wready}, 0);
        chk("midrst_dev", {dev_req, dev_we, dev_addr}, 0);
        chk("midrst_rdata", {rdata, rid, rresp, rlast}, 0);
        #20;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        va = '{0, 4'h2, 32'h0000_0000, 8'd0, 3'd2, BURST_INCR, 4'hF, -1, RESP_OKAY};
        run_vec(va);
        chk("no_dual_ready_end", dual_rdy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_dbg_mem_slave.md
Name: axi_dbg_mem_slave

Overview:
- AXI4 full slave (responder) that terminates the debug crossbar port (0x0000_0000–0x0000_080F) and drives the debug module's single-port device memory bus (req/we/addr/be/wdata/rdata).
- Accepts single-beat and burst reads/writes from the core's AXI master through the crossbar.
- Serializes reads and writes onto the one device port.
- Echoes IDs and returns OKAY/SLVERR responses.

Parameters:
- ADDR_W, 32, AXI and device address width.
- DATA_W, 32, data width; only 32 is supported.
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  core clock; AXI and device sides share it.
- rst  in  1  reset, asynchronous, active-high.
- s_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/ADDR_W/8/3/2/1  write address channel.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_W/4/1/1  write data channel.
- s_axi_wready  out  1  write data ready.
- s_axi_bid/bresp/bvalid  out  ID_W/2/1  write response channel.
- s_axi_bready  in  1  write response ready.
- s_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/8/3/2/1  read address channel.
- s_axi_arready  out  1  read address ready.
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data channel.
- s_axi_rready  in  1  read data ready.
- dev_req  out  1  device access strobe.
- dev_we  out  1  1 = write.
- dev_addr  out  ADDR_W  word-aligned address, {addr[31:2],2'b00}.
- dev_be  out  4  byte enables.
- dev_wdata  out  DATA_W  write data.
- dev_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read dev_req.

Behaviour:
- Reset:
  - State is IDLE.
  - All ready/valid outputs and dev_req/dev_we are 0.
  - dev_addr, dev_be, dev_wdata, rdata, rresp, bresp, rid and bid are 0.
  - The arbitration pointer last_rd is 0, so a read wins the first tie.
  - Reset mid-burst aborts silently: no response is issued and all captured state is cleared.
- FSM states: IDLE, RD_REQ, RD_CAP, RD_RESP, WR_DATA, WR_RESP.
- IDLE:
  - arready = 1 only if the read is granted; awready = 1 only if the write is granted. The two are never asserted together.
  - If both arvalid and awvalid are high: grant the write if last_rd = 1, else the read. Toggle last_rd on each grant.
  - On a handshake, capture id, addr, len, size and burst, and load beat_cnt = len.
- Read path:
  - RD_REQ: dev_req = 1, we = 0.
  - RD_CAP: rdata_q <= dev_rdata.
  - RD_RESP: rvalid = 1; rlast = (beat_cnt == 0); rid = captured id. rdata and rresp are held stable until rready.
  - On an rready handshake: if last, go to IDLE; else advance the address, decrement beat_cnt and go to RD_REQ.
  - Latency is AR handshake at cycle 0 to rvalid at cycle 3; each later beat takes 3 cycles when rready is held high.
- Write path:
  - WR_DATA: wready = 1. On wvalid: dev_req = 1, dev_we = 1, dev_be = wstrb and dev_wdata = wdata in the same cycle (combinational from the W channel, qualified by state).
  - Advance the address and decrement beat_cnt on each beat.
  - After the beat with beat_cnt == 0, go to WR_RESP.
  - WR_RESP: bvalid = 1, bid = captured id; hold until bready, then go to IDLE.
- Burst address:
  - FIXED (00): address held for every beat.
  - INCR (01): next = addr + (1 << size), 32-bit wrap-around with no error.
  - WRAP (10) and reserved (11): no dev_req is issued for any beat.
    - Reads return rdata = 0 with rresp = SLVERR (2'b10) on every beat.
    - Writes consume all beats and then return bresp = SLVERR.
- wlast check:
  - Burst length is set by awlen, not by wlast.
  - If wlast is 1 on a non-final beat, or 0 on the final beat, the write still completes to the device and bresp = SLVERR.
- arsize/awsize > 2 returns SLVERR for the whole transaction, with no device access.
- Narrow transfers (size < 2): reads return the full word; writes use wstrb as given.
- dev_req is asserted for at most 1 cycle per beat; the device is never stalled.

Decomposition:
- axi_dbg_pkg holds:
  - the state enum;
  - burst constants BURST_FIXED/INCR/WRAP;
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
- Sub-module axi_burst_addr_gen: combinational next-address and error flag from (addr, size, burst). Shared by both paths.

Test Plan:
- Single read at araddr = 0x100 (arlen = 0, size 2, INCR) with the device returning 0xDEADBEEF: dev_req at cycle 1 with dev_addr 0x100; rvalid at cycle 3 with rdata = 0xDEADBEEF, rlast = 1, rresp = OKAY, rid = awid-independent captured arid.
- INCR write burst at awaddr = 0x200, awlen = 3, wstrb = 0xF, data 1..4: dev_addr sequence 0x200/204/208/20C with we = 1; then bvalid with bresp = OKAY and bid = 0x5.
- Simultaneous arvalid and awvalid after reset:
  - read granted first, then write;
  - a second simultaneous pair then grants write first;
  - arready and awready are never high in the same cycle.
- Read burst with arburst = WRAP, arlen = 1: 2 beats with rresp = SLVERR and rdata = 0, rlast on the second beat, and no dev_req ever asserted.
- Write burst with awlen = 2 and wlast asserted on beat 1: 3 device writes occur, then bresp = SLVERR; rready/bready backpressure of 4 cycles keeps rdata/bresp stable.
- Assert rst during beat 2 of a 4-beat read:
  - all outputs return to 0 asynchronously;
  - a subsequent single read at 0x0 completes normally with OKAY.
